pipe_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage core.
- Drives the write-enable, flush and bubble controls of the PC, IF/ID and ID/EX buffers, plus the EX/MEM hold.
- Handles three cases: load-use hazards (one bubble), taken-branch flushes, and multi-cycle data-memory waits with timeout.
- Sits beside the decode stage; consumes register indices and stage status, produces pipeline control only (no data).

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_wait_timer.sv | 52 +++++
 rtl/pipe_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Purpose  : Shared types and constants for the pipeline hazard controller.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  // Register index width of the integer register file
  localparam int REG_IDX_W = 5;

  // x0 is hard-wired to zero, so it never carries a dependency
  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  // Sequencer states
  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } pipe_state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_wait_timer
//  Purpose  : Counts cycles spent waiting on data memory, flags expiry at
//             MEM_TIMEOUT stall cycles and keeps a sticky timeout error.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_wait_timer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,    // RUN-state access that did not complete
  input  logic waiting_i,  // sequencer sits in WAIT_MEM
  input  logic ready_i,    // memory completes this cycle
  output logic expired_o,  // last permitted wait cycle passed with no ready
  output logic err_o
);

  // The stall cycle that starts the wait counts as cycle 1
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;
  logic             r_err;

  assign expired_o = waiting_i & ~ready_i & (r_count == c_LAST);
  assign err_o     = r_err;

  // Wait counter and sticky timeout flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (start_i) begin
      r_count <= CNT_W'(1);
    end else if (waiting_i) begin
      if (ready_i || expired_o) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
      if (expired_o) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Purpose  : Pipeline sequencing controller for the 5-stage core. Produces
//             PC / IF-ID / ID-EX / EX-MEM enables, flushes and bubbles for
//             load-use hazards, taken branches and data-memory waits.
//  Options  : PIPE_HAZARD_PERF_EN adds saturating stall / flush counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_valid_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_use_rs2_i,
  input  logic                 ex_valid_i,
  input  logic                 ex_memread_i,
  input  logic [REG_IDX_W-1:0] ex_rsd_i,
  input  logic                 ex_branch_taken_i,
  input  logic                 mem_req_i,
  input  logic                 mem_ready_i,
  output logic                 pc_write_o,
  output logic                 ifid_write_o,
  output logic                 ifid_flush_o,
  output logic                 idex_write_o,
  output logic                 idex_bubble_o,
  output logic                 exmem_write_o,
  output logic                 stall_o,
  output logic                 err_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]          stall_cnt_o,
  output logic [31:0]          flush_cnt_o
`endif
);

  pipe_state_t r_state;
  pipe_state_t w_next_state;

  logic w_load_use;
  logic w_mem_stall;
  logic w_timer_start;
  logic w_timer_expired;

  // A load in EX feeding a source operand of the instruction in ID
  assign w_load_use = ex_valid_i & ex_memread_i & (ex_rsd_i != ZERO_REG) & id_valid_i &
                      ((ex_rsd_i == id_rs1_i) | (id_use_rs2_i & (ex_rsd_i == id_rs2_i)));

  // An access that does not finish in its first cycle freezes the pipe
  assign w_mem_stall   = mem_req_i & ~mem_ready_i;
  assign w_timer_start = (r_state == RUN) & w_mem_stall;

  pipe_hazard_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (w_timer_start),
    .waiting_i (r_state == WAIT_MEM),
    .ready_i   (mem_ready_i),
    .expired_o (w_timer_expired),
    .err_o     (err_o)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and pipeline control decode, memory wait first, then branch, then load-use
  always_comb begin
    w_next_state  = r_state;
    pc_write_o    = 1'b1;
    ifid_write_o  = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_write_o  = 1'b1;
    idex_bubble_o = 1'b0;
    exmem_write_o = 1'b1;
    stall_o       = 1'b0;

    if (rst_i) begin
      // Load invalid entries everywhere while reset is applied
      ifid_flush_o  = 1'b1;
      idex_bubble_o = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_stall) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_write_o  = 1'b0;
            exmem_write_o = 1'b0;
            stall_o       = 1'b1;
            w_next_state  = WAIT_MEM;
          end else if (ex_branch_taken_i) begin
            // ID holds a wrong-path instruction, so its hazard is irrelevant
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
          end else if (w_load_use) begin
            // Hold PC and IF/ID one cycle, insert a single bubble into EX
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
            stall_o       = 1'b1;
          end
        end
        WAIT_MEM: begin
          // The exit cycle still holds every stage
          pc_write_o    = 1'b0;
          ifid_write_o  = 1'b0;
          idex_write_o  = 1'b0;
          exmem_write_o = 1'b0;
          stall_o       = 1'b1;
          if (mem_ready_i || w_timer_expired) begin
            w_next_state = RUN;
          end
        end
        default: begin
          w_next_state = RUN;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Saturating performance counters for stall and flush cycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_o && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (ifid_flush_o && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Purpose  : Self-checking bench for pipe_hazard_ctrl: directed scenarios
//             with literal expectations plus randomized traffic compared
//             each cycle against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs2, ex_valid, ex_memread, br, mem_req, mem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rsd;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, stall, err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Behavioural model state: are we inside a memory wait, how many stall
  // cycles this access has used so far, sticky error, event counts
  bit     m_wait    = 1'b0;
  int     m_elapsed = 0;
  bit     m_err     = 1'b0;
  longint m_stalls  = 0;
  longint m_flushes = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .id_valid_i        (id_valid),
    .id_rs1_i          (id_rs1),
    .id_rs2_i          (id_rs2),
    .id_use_rs2_i      (id_use_rs2),
    .ex_valid_i        (ex_valid),
    .ex_memread_i      (ex_memread),
    .ex_rsd_i          (ex_rsd),
    .ex_branch_taken_i (br),
    .mem_req_i         (mem_req),
    .mem_ready_i       (mem_ready),
    .pc_write_o        (pc_write),
    .ifid_write_o      (ifid_write),
    .ifid_flush_o      (ifid_flush),
    .idex_write_o      (idex_write),
    .idex_bubble_o     (idex_bubble),
    .exmem_write_o     (exmem_write),
    .stall_o           (stall),
    .err_o             (err)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
`endif
  );

  function automatic bit load_use();
    return ex_valid && ex_memread && (ex_rsd != 5'd0) && id_valid &&
           ((ex_rsd == id_rs1) || (id_use_rs2 && (ex_rsd == id_rs2)));
  endfunction

  // Expected control vector {pc, ifid, flush, idex, bubble, exmem, stall}
  function automatic logic [6:0] expect_ctrl();
    if (rst)                          return 7'b1111110;
    else if (m_wait)                  return 7'b0000001;
    else if (mem_req && !mem_ready)   return 7'b0000001;
    else if (br)                      return 7'b1111110;
    else if (load_use())              return 7'b0001111;
    else                              return 7'b1101010;
  endfunction

  // Advance the model on every rising edge
  always @(posedge clk) begin
    logic [6:0] e;
    e = expect_ctrl();
    if (rst) begin
      m_wait = 0; m_elapsed = 0; m_err = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      if (e[0])  m_stalls++;
      if (e[4])  m_flushes++;
      if (!m_wait) begin
        if (mem_req && !mem_ready) begin
          m_wait = 1; m_elapsed = 1;
        end
      end else if (mem_ready) begin
        m_wait = 0; m_elapsed = 0;
      end else if (m_elapsed + 1 == TO) begin
        m_wait = 0; m_elapsed = 0; m_err = 1;
      end else begin
        m_elapsed++;
      end
    end
    cmp_en = 1'b1;
  end

  // Compare DUT against the model midway through every cycle
  always @(negedge clk) begin
    logic [6:0] e, a;
    if (cmp_en) begin
      e = expect_ctrl();
      a = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, stall};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL model_ctrl t=%0t actual=%b required=%b", $time, a, e);
      end
      checks++;
      if (err !== m_err) begin
        failures++;
        $display("FAIL model_err t=%0t actual=%b required=%b", $time, err, m_err);
      end
`ifdef PIPE_HAZARD_PERF_EN
      checks++;
      if (stall_cnt !== 32'(m_stalls) || flush_cnt !== 32'(m_flushes)) begin
        failures++;
        $display("FAIL model_perf t=%0t actual=%0d/%0d required=%0d/%0d",
                 $time, stall_cnt, flush_cnt, m_stalls, m_flushes);
      end
`endif
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_memread = 0; ex_rsd = 0; br = 0; mem_req = 0; mem_ready = 0;
  endtask

  // Move to the start of the next cycle's input window
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input logic [4:0] rsd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic use2);
    ex_valid = 1; ex_memread = 1; ex_rsd = rsd;
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_use_rs2 = use2;
  endtask

  initial begin
    rst = 1;
    idle();
    cyc();
    cyc();
    #2;
    chk("rst_pc_write", pc_write, 1);
    chk("rst_flush",    ifid_flush, 1);
    chk("rst_bubble",   idex_bubble, 1);
    chk("rst_stall",    stall, 0);
    chk("rst_err",      err, 0);

    // Load-use on rs1: one stall, then free-running
    cyc(); rst = 0; idle(); set_load(5, 5, 0, 0); #2;
    chk("lu_pc_write",   pc_write, 0);
    chk("lu_ifid_write", ifid_write, 0);
    chk("lu_bubble",     idex_bubble, 1);
    chk("lu_stall",      stall, 1);
    cyc(); idle(); id_valid = 1; id_rs1 = 5; #2;
    chk("lu_after_pc",   pc_write, 1);
    chk("lu_after_stall", stall, 0);

    // x0 never hazards; rs2 only when it is read
    cyc(); idle(); set_load(0, 0, 0, 1); #2;
    chk("zero_reg_stall", stall, 0);
    cyc(); idle(); set_load(7, 1, 7, 0); #2;
    chk("rs2_unused_stall", stall, 0);
    cyc(); idle(); set_load(7, 1, 7, 1); #2;
    chk("rs2_used_stall", stall, 1);

    // Branch beats load-use
    cyc(); idle(); set_load(3, 3, 0, 0); br = 1; #2;
    chk("br_flush",  ifid_flush, 1);
    chk("br_bubble", idex_bubble, 1);
    chk("br_pc",     pc_write, 1);
    chk("br_stall",  stall, 0);

    // Three-cycle miss then ready: four stall cycles, branch ignored
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); mem_req = 1; mem_ready = (i == 3); br = (i == 1); #2;
      chk("mw_stall", stall, 1);
      chk("mw_exmem", exmem_write, 0);
      chk("mw_flush", ifid_flush, 0);
    end
    cyc(); idle(); #2;
    chk("mw_done_stall", stall, 0);
    chk("mw_done_pc",    pc_write, 1);

    // Timeout after TO stall cycles, sticky error
    for (int i = 0; i < TO; i++) begin
      cyc(); idle(); mem_req = 1; #2;
      chk("to_stall", stall, 1);
      chk("to_err_low", err, 0);
    end
    cyc(); idle(); #2;
    chk("to_exit_stall", stall, 0);
    chk("to_err_set",    err, 1);
    cyc(); idle(); #2;
    chk("to_err_sticky", err, 1);

    // Reset in the middle of a wait
    cyc(); idle(); mem_req = 1; #2;
    chk("rw_stall", stall, 1);
    cyc(); rst = 1; #2;
    chk("rw_rst_stall", stall, 0);
    cyc(); rst = 0; idle(); #2;
    chk("rw_after_stall", stall, 0);
    chk("rw_after_err",   err, 0);

`ifdef PIPE_HAZARD_PERF_EN
    cyc(); rst = 1; idle();
    for (int i = 0; i < 3; i++) begin
      cyc(); rst = 0; idle(); set_load(2, 2, 0, 0);
      cyc(); idle();
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); idle(); br = 1;
      cyc(); idle();
    end
    #2;
    chk("perf_stall_cnt", stall_cnt, 3);
    chk("perf_flush_cnt", flush_cnt, 2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst        = ($urandom_range(0, 199) == 0);
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs1     = 5'($urandom_range(0, 3));
      id_rs2     = 5'($urandom_range(0, 3));
      id_use_rs2 = $urandom_range(0, 1) != 0;
      ex_valid   = ($urandom_range(0, 3) != 0);
      ex_memread = $urandom_range(0, 1) != 0;
      ex_rsd     = 5'($urandom_range(0, 3));
      br         = ($urandom_range(0, 7) == 0);
      mem_req    = ($urandom_range(0, 3) == 0);
      mem_ready  = ($urandom_range(0, 2) == 0);
    end
    cyc(); idle(); rst = 0;
    cyc();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
